// File: rtl/dmem_resp_pkg.sv
// dmem_resp_pkg: shared constants, FSM encoding and lane helpers for the
// data-memory responder and its byte-enabled RAM.
package dmem_resp_pkg;

  // Byte lanes per 32-bit word
  localparam int BE_WIDTH = 4;

  // Idle values for the RAM control and data paths
  localparam logic [31:0]         ZERO_WORD     = 32'h0000_0000;
  localparam logic                READ_DISABLE  = 1'b0;
  localparam logic [BE_WIDTH-1:0] WRITE_DISABLE = '0;

  // RV32I load funct3 codes
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  // RV32I store funct3 codes
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  // Access sequencing: accept in IDLE, optional WAIT, one RESP cycle
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  // Byte enables plus lane-replicated write data for one store
  typedef struct packed {
    logic [BE_WIDTH-1:0] be;
    logic [31:0]         data;
  } store_lanes_t;

  // Stores replicate the narrow datum into every lane so the byte enables
  // alone pick the destination. Misaligned halves/words fall back to the
  // aligned lane because the low offset bits are not used there.
  function automatic store_lanes_t store_lanes(
    input logic [2:0]  funct3,
    input logic [1:0]  off,
    input logic [31:0] wdata
  );
    store_lanes_t r;
    r.be   = WRITE_DISABLE;
    r.data = ZERO_WORD;
    case (funct3)
      F3_SB: begin
        r.be   = 4'b0001 << off;
        r.data = {4{wdata[7:0]}};
      end
      F3_SH: begin
        r.be   = 4'b0011 << {off[1], 1'b0};
        r.data = {2{wdata[15:0]}};
      end
      F3_SW: begin
        r.be   = 4'b1111;
        r.data = wdata;
      end
      default: begin
        // Unknown store width: no lanes written, access still completes
        r.be   = WRITE_DISABLE;
        r.data = ZERO_WORD;
      end
    endcase
    return r;
  endfunction

  // Picks the addressed byte/half out of the RAM word and extends it.
  // Unknown load codes return the full word.
  function automatic logic [31:0] load_extract(
    input logic [2:0]  funct3,
    input logic [1:0]  off,
    input logic [31:0] word
  );
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = word[{off, 3'b000} +: 8];
    h = off[1] ? word[31:16] : word[15:0];
    case (funct3)
      F3_LB:   r = {{24{b[7]}}, b};
      F3_LBU:  r = {24'h000000, b};
      F3_LH:   r = {{16{h[15]}}, h};
      F3_LHU:  r = {16'h0000, h};
      default: r = word;
    endcase
    return r;
  endfunction

  // Half accesses with an odd offset, or word accesses off a word boundary.
  // LH and SH share the code 001; LHU (101) only exists as a load.
  function automatic logic is_misaligned(
    input logic       is_store,
    input logic [2:0] funct3,
    input logic [1:0] off
  );
    logic r;
    case (funct3)
      F3_LH:   r = off[0];
      F3_LHU:  r = ~is_store & off[0];
      F3_LW:   r = (off != 2'b00);
      default: r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/dmem_ram.sv
// dmem_ram: single-port synchronous RAM, one byte-wide array per lane with
// independent byte-enable writes and a registered read port. Contents are
// never reset; the read register only updates when re is high, so the last
// word read stays on rdata until the next read.
module dmem_ram
  import dmem_resp_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int AW          = $clog2(DEPTH_WORDS)
) (
  input  logic                clk,
  input  logic                re,
  input  logic [BE_WIDTH-1:0] be,
  input  logic [AW-1:0]       addr,
  input  logic [31:0]         wdata,
  output logic [31:0]         rdata
);

  for (genvar gi = 0; gi < BE_WIDTH; gi++) begin : g_lane
    logic [7:0] lane_mem [DEPTH_WORDS];
    logic [7:0] lane_rd_reg;

    // Byte-lane write under its enable, registered read under re
    always_ff @(posedge clk) begin
      if (be[gi]) begin
        lane_mem[addr] <= wdata[gi*8 +: 8];
      end
      if (re) begin
        lane_rd_reg <= lane_mem[addr];
      end
    end

    assign rdata[gi*8 +: 8] = lane_rd_reg;
  end

endmodule

// File: rtl/dmem_resp.sv
// dmem_resp: data-memory responder for the MEM-stage load/store port.
// A request seen in IDLE raises hold_req_o at once; the accept edge commits
// stores and launches the RAM read, WAIT_CYCLES wait cycles follow, and a
// single RESP cycle drops hold and strobes rsp_valid_o with the extended
// load data (zero for stores).
// Build option: define DMEM_MISALIGN_TRAP_EN to suppress misaligned
// half/word accesses (no write, zero data) and report them on misalign_o.
// Without it misalign_o is 0 and misaligned accesses use the aligned lane.
module dmem_resp
  import dmem_resp_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk_100MHz,
  input  logic        arst_n,
  input  logic        req_rena_i,
  input  logic        req_wena_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  input  logic [2:0]  req_funct3_i,
  output logic        hold_req_o,
  output logic        rsp_valid_o,
  output logic [31:0] rsp_rdata_o,
  output logic        misalign_o
);

  localparam int AW    = $clog2(DEPTH_WORDS);
  localparam int CNT_W = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_CYCLES);

  state_t              state_reg;
  state_t              state_next;
  logic [CNT_W-1:0]    cnt_reg;
  logic [CNT_W-1:0]    cnt_next;

  logic                req;
  logic                accept;
  logic                req_misalign;
  logic [AW-1:0]       word_idx;
  store_lanes_t        lanes;

  logic [1:0]          off_reg;
  logic [2:0]          funct3_reg;
  logic                is_store_reg;
  logic                misalign_reg;
  logic [31:0]         rdata_hold_reg;

  logic                ram_re;
  logic [BE_WIDTH-1:0] ram_be;
  logic [31:0]         ram_rdata;
  logic [31:0]         load_data;

  // Address bits above the RAM index are ignored so addresses wrap
  logic                unused_addr_bits;
  assign unused_addr_bits = ^req_addr_i[31:AW+2];

  assign req      = req_rena_i | req_wena_i;
  assign word_idx = req_addr_i[AW+1:2];
  assign lanes    = store_lanes(req_funct3_i, req_addr_i[1:0], req_wdata_i);

`ifdef DMEM_MISALIGN_TRAP_EN
  assign req_misalign = is_misaligned(req_wena_i, req_funct3_i, req_addr_i[1:0]);
`else
  assign req_misalign = 1'b0;
`endif

  // A store takes priority over a simultaneous load, so the read is only
  // launched for pure loads; trapped stores write no lanes.
  assign ram_re = (accept & req_rena_i & ~req_wena_i) ? 1'b1 : READ_DISABLE;
  assign ram_be = (accept & req_wena_i & ~req_misalign) ? lanes.be : WRITE_DISABLE;

  dmem_ram #(
    .DEPTH_WORDS (DEPTH_WORDS)
  ) u_ram (
    .clk   (clk_100MHz),
    .re    (ram_re),
    .be    (ram_be),
    .addr  (word_idx),
    .wdata (lanes.data),
    .rdata (ram_rdata)
  );

  // State register and wait counter
  always_ff @(posedge clk_100MHz or negedge arst_n) begin
    if (!arst_n) begin
      state_reg <= ST_IDLE;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  // Next state: IDLE accepts, WAIT counts 1..WAIT_CYCLES, RESP lasts one cycle
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      ST_IDLE: begin
        if (req) begin
          if (WAIT_CYCLES == 0) begin
            state_next = ST_RESP;
          end else begin
            state_next = ST_WAIT;
            cnt_next   = CNT_ONE;
          end
        end
      end
      ST_WAIT: begin
        if (cnt_reg >= CNT_LAST) begin
          state_next = ST_RESP;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + CNT_ONE;
        end
      end
      ST_RESP: begin
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  // Outputs per state: hold while a request is pending or in flight
  always_comb begin
    hold_req_o  = 1'b0;
    rsp_valid_o = 1'b0;
    accept      = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        hold_req_o = req;
        accept     = req;
      end
      ST_WAIT: begin
        hold_req_o = 1'b1;
      end
      ST_RESP: begin
        rsp_valid_o = 1'b1;
      end
      default: begin
        hold_req_o  = 1'b0;
        rsp_valid_o = 1'b0;
        accept      = 1'b0;
      end
    endcase
  end

  // Capture the access attributes needed to shape the response
  always_ff @(posedge clk_100MHz or negedge arst_n) begin
    if (!arst_n) begin
      off_reg      <= 2'b00;
      funct3_reg   <= 3'b000;
      is_store_reg <= 1'b0;
      misalign_reg <= 1'b0;
    end else if (accept) begin
      off_reg      <= req_addr_i[1:0];
      funct3_reg   <= req_funct3_i;
      is_store_reg <= req_wena_i;
      misalign_reg <= req_misalign;
    end
  end

  // Stores and suppressed accesses return zero; loads return extended data
  assign load_data = (is_store_reg | misalign_reg)
                   ? ZERO_WORD
                   : load_extract(funct3_reg, off_reg, ram_rdata);

  // Keep the last response value on the data bus between responses
  always_ff @(posedge clk_100MHz or negedge arst_n) begin
    if (!arst_n) begin
      rdata_hold_reg <= ZERO_WORD;
    end else if (rsp_valid_o) begin
      rdata_hold_reg <= load_data;
    end
  end

  // The RAM word only lands on the accept edge, so the response cycle
  // presents the live extraction and the register covers every other cycle.
  assign rsp_rdata_o = rsp_valid_o ? load_data : rdata_hold_reg;

`ifdef DMEM_MISALIGN_TRAP_EN
  assign misalign_o = rsp_valid_o & misalign_reg;
`else
  assign misalign_o = 1'b0;
`endif

endmodule

// File: tb/tb_dmem_resp.sv
// tb_dmem_resp: scoreboard bench for dmem_resp. Two instances run side by
// side: unit 0 with two wait cycles, unit 1 with none. A byte-array memory
// model produces the expected response of every access; the driver pushes
// it at the accept edge and a monitor pops and compares on rsp_valid_o.
module tb_dmem_resp;

  localparam int DEPTH  = 64;
  localparam int NBYTES = DEPTH * 4;

`ifdef DMEM_MISALIGN_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  localparam logic [2:0] LB = 3'd0, LH = 3'd1, LW = 3'd2, LBU = 3'd4, LHU = 3'd5;
  localparam logic [2:0] SB = 3'd0, SH = 3'd1, SW = 3'd2;

  logic        clk = 1'b0;
  logic        arst_n;
  logic        rena  [2];
  logic        wena  [2];
  logic [31:0] addr  [2];
  logic [31:0] wdata [2];
  logic [2:0]  f3    [2];
  logic        hold  [2];
  logic        valid [2];
  logic [31:0] rdata [2];
  logic        mis   [2];

  logic [7:0]  ref_mem [2][NBYTES];
  logic [32:0] exp_q0[$];
  logic [32:0] exp_q1[$];

  int pass_cnt  = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  dmem_resp #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(2)) dut_w2 (
    .clk_100MHz   (clk),
    .arst_n       (arst_n),
    .req_rena_i   (rena[0]),
    .req_wena_i   (wena[0]),
    .req_addr_i   (addr[0]),
    .req_wdata_i  (wdata[0]),
    .req_funct3_i (f3[0]),
    .hold_req_o   (hold[0]),
    .rsp_valid_o  (valid[0]),
    .rsp_rdata_o  (rdata[0]),
    .misalign_o   (mis[0])
  );

  dmem_resp #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(0)) dut_w0 (
    .clk_100MHz   (clk),
    .arst_n       (arst_n),
    .req_rena_i   (rena[1]),
    .req_wena_i   (wena[1]),
    .req_addr_i   (addr[1]),
    .req_wdata_i  (wdata[1]),
    .req_funct3_i (f3[1]),
    .hold_req_o   (hold[1]),
    .rsp_valid_o  (valid[1]),
    .rsp_rdata_o  (rdata[1]),
    .misalign_o   (mis[1])
  );

  function automatic int wc_of(input int u);
    return (u == 0) ? 2 : 0;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  function automatic int q_size(input int u);
    return (u == 0) ? exp_q0.size() : exp_q1.size();
  endfunction

  task automatic push_exp(input int u, input logic [32:0] e);
    if (u == 0) exp_q0.push_back(e);
    else        exp_q1.push_back(e);
  endtask

  task automatic q_pop(input int u, output logic [32:0] e);
    if (u == 0) e = exp_q0.pop_front();
    else        e = exp_q1.pop_front();
  endtask

  task automatic drop_last(input int u);
    if (u == 0) begin
      if (exp_q0.size() > 0) void'(exp_q0.pop_back());
    end else begin
      if (exp_q1.size() > 0) void'(exp_q1.pop_back());
    end
  endtask

  // Byte-addressed memory model: little-endian, address wraps at NBYTES,
  // narrow accesses land on the naturally aligned half/word.
  task automatic model_access(input int u, input logic rd, input logic wr,
                              input logic [31:0] a, input logic [31:0] wd,
                              input logic [2:0] fn, output logic [32:0] e);
    int          base, hb, wb;
    logic        misal;
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] w, val;
    base  = int'(a & 32'(NBYTES - 1));
    hb    = base - (base % 2);
    wb    = base - (base % 4);
    misal = 1'b0;
    if (TRAP_EN) begin
      if (fn == 3'd2) misal = (a[1:0] != 2'b00);
      else if (fn == 3'd1 || (fn == 3'd5 && !wr)) misal = a[0];
    end
    b = ref_mem[u][base];
    h = {ref_mem[u][hb+1], ref_mem[u][hb]};
    w = {ref_mem[u][wb+3], ref_mem[u][wb+2], ref_mem[u][wb+1], ref_mem[u][wb]};
    if (wr) begin
      if (!misal) begin
        case (fn)
          3'd0: ref_mem[u][base] = wd[7:0];
          3'd1: begin
            ref_mem[u][hb]   = wd[7:0];
            ref_mem[u][hb+1] = wd[15:8];
          end
          3'd2: for (int i = 0; i < 4; i++) ref_mem[u][wb+i] = wd[8*i +: 8];
          default: ;
        endcase
      end
      val = 32'h0;
    end else begin
      case (fn)
        3'd0:    val = {{24{b[7]}}, b};
        3'd4:    val = {24'h0, b};
        3'd1:    val = {{16{h[15]}}, h};
        3'd5:    val = {16'h0, h};
        default: val = w;
      endcase
      if (misal) val = 32'h0;
    end
    e = {misal, val};
  endtask

  // One access, entered with the unit idle just after a rising edge; returns
  // in the idle cycle following the response.
  task automatic do_txn(input int u, input logic rd, input logic wr,
                        input logic [31:0] a, input logic [31:0] wd, input logic [2:0] fn);
    logic [32:0] e;
    int k, h;
    model_access(u, rd, wr, a, wd, fn, e);
    rena[u] = rd; wena[u] = wr; addr[u] = a; wdata[u] = wd; f3[u] = fn;
    #1;
    check("hold_on_request", 32'(hold[u]), 32'd1);
    h = 1;
    @(posedge clk);
    push_exp(u, e);
    #1;
    rena[u] = 1'b0; wena[u] = 1'b0;
    k = 1;
    while (!valid[u] && k <= 20) begin
      if (hold[u]) h++;
      @(posedge clk); #1;
      k++;
    end
    if (!valid[u]) begin
      total_cnt++;
      $display("FAIL rsp_timeout u=%0d: got no rsp_valid_o in 20 cycles, expected one after %0d", u, wc_of(u) + 1);
      drop_last(u);
    end else begin
      check("latency", 32'(k), 32'(wc_of(u) + 1));
      check("hold_in_resp", 32'(hold[u]), 32'd0);
      check("hold_cycles", 32'(h), 32'(wc_of(u) + 1));
    end
    @(posedge clk); #1;
  endtask

  // Monitor: every response strobe must match the oldest expectation
  initial begin : monitor
    logic [32:0] e;
    forever begin
      @(negedge clk);
      for (int u = 0; u < 2; u++) begin
        if (valid[u] === 1'b1) begin
          if (q_size(u) == 0) begin
            total_cnt++;
            $display("FAIL unexpected_rsp u=%0d: got rsp_valid_o=1, expected no response", u);
          end else begin
            q_pop(u, e);
            check("rsp_rdata", rdata[u], e[31:0]);
            check("misalign", 32'(mis[u]), 32'(e[32]));
            $display("rsp u=%0d rdata=0x%08h misalign=%0b", u, rdata[u], mis[u]);
          end
        end
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: got no end of test, expected finish within 500000 time units");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    logic [32:0] e;
    logic        rd, wr;
    for (int u = 0; u < 2; u++) begin
      rena[u] = 1'b0; wena[u] = 1'b0; addr[u] = '0; wdata[u] = '0; f3[u] = '0;
    end
    arst_n = 1'b0;
    #12;
    for (int u = 0; u < 2; u++) begin
      check("reset_hold", 32'(hold[u]), 32'd0);
      check("reset_valid", 32'(valid[u]), 32'd0);
      check("reset_rdata", rdata[u], 32'd0);
      check("reset_misalign", 32'(mis[u]), 32'd0);
    end
    #10;
    arst_n = 1'b1;
    @(posedge clk); #1;

    // Known contents everywhere before any load
    for (int u = 0; u < 2; u++)
      for (int i = 0; i < DEPTH; i++)
        do_txn(u, 1'b0, 1'b1, 32'(i * 4), $urandom(), SW);

    // Directed sequence on the two-wait-cycle unit
    do_txn(0, 0, 1, 32'h10, 32'hDEADBEEF, SW);
    do_txn(0, 1, 0, 32'h10, 32'h0, LW);
    do_txn(0, 0, 1, 32'h13, 32'h00000080, SB);
    do_txn(0, 1, 0, 32'h13, 32'h0, LB);
    do_txn(0, 1, 0, 32'h13, 32'h0, LBU);
    do_txn(0, 1, 0, 32'h10, 32'h0, LW);
    do_txn(0, 0, 1, 32'h12, 32'h00008001, SH);
    do_txn(0, 1, 0, 32'h12, 32'h0, LH);
    do_txn(0, 1, 0, 32'h12, 32'h0, LHU);
    do_txn(0, 1, 0, 32'h10, 32'h0, LW);
    do_txn(0, 1, 1, 32'h20, 32'hCAFEF00D, SW);
    do_txn(0, 1, 0, 32'h20, 32'h0, LW);
    do_txn(0, 0, 1, 32'h20, 32'h11111111, 3'd7);
    do_txn(0, 1, 0, 32'h20, 32'h0, LW);
    do_txn(0, 1, 0, 32'h22, 32'h0, 3'd3);
    do_txn(0, 0, 1, 32'hFFFFFF14, 32'hA5A55A5A, SW);
    do_txn(0, 1, 0, 32'h14, 32'h0, LW);
    do_txn(0, 1, 0, 32'h13, 32'h0, LH);
    do_txn(0, 0, 1, 32'h11, 32'h12345678, SW);
    do_txn(0, 1, 0, 32'h10, 32'h0, LW);

    // Reset in the middle of a load's wait phase: no response may follow
    rena[0] = 1'b1; addr[0] = 32'h10; f3[0] = LW;
    model_access(0, 1'b1, 1'b0, 32'h10, 32'h0, LW, e);
    @(posedge clk);
    push_exp(0, e);
    #1;
    rena[0] = 1'b0;
    #2;
    arst_n = 1'b0;
    drop_last(0);
    #1;
    check("midreset_hold", 32'(hold[0]), 32'd0);
    check("midreset_valid", 32'(valid[0]), 32'd0);
    check("midreset_rdata", rdata[0], 32'd0);
    check("midreset_misalign", 32'(mis[0]), 32'd0);
    @(posedge clk); @(posedge clk); #2;
    arst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    do_txn(0, 1, 0, 32'h10, 32'h0, LW);

    // Back-to-back loads on the zero-wait unit
    for (int i = 0; i < 6; i++) do_txn(1, 1'b1, 1'b0, 32'(i * 4), 32'h0, LW);
    do_txn(1, 0, 1, 32'h13, 32'h000000F0, SB);
    do_txn(1, 1, 0, 32'h13, 32'h0, LB);
    do_txn(1, 1, 0, 32'h12, 32'h0, LHU);

    // Randomised mix on both units
    for (int u = 0; u < 2; u++) begin
      for (int n = 0; n < 120; n++) begin
        rd = 1'($urandom_range(0, 1));
        wr = 1'($urandom_range(0, 1));
        if (!rd && !wr) rd = 1'b1;
        do_txn(u, rd, wr, $urandom(), $urandom(), 3'($urandom_range(0, 7)));
      end
    end

    repeat (4) @(posedge clk);
    #1;
    check("queue0_drained", 32'(exp_q0.size()), 32'd0);
    check("queue1_drained", 32'(exp_q1.size()), 32'd0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
